// File: rtl/sargantana_icache_way_array.sv
// Instruction-cache way storage: NUM_WAYS independent line arrays sharing one index,
// cleared by a full-depth zero sweep after reset or flush, single-cycle registered reads.
module sargantana_icache_way_bank #(
  parameter int ICACHE_DEPTH = 64,
  parameter int SET_WIDHT    = 256,
  parameter int ADDR_WIDHT   = 6
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  wr_en,
  input  logic                  rd_load,
  input  logic                  rd_sel,
  input  logic                  clr,
  input  logic [ADDR_WIDHT-1:0] addr,
  input  logic [SET_WIDHT-1:0]  wdata,
  output logic [SET_WIDHT-1:0]  rdata
);
  // Storage itself has no reset; only the sweep guarantees cleared lines.
  logic [SET_WIDHT-1:0] mem [ICACHE_DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[addr] <= wdata;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)      rdata <= '0;
    else if (clr)     rdata <= '0;
    else if (rd_load) rdata <= rd_sel ? mem[addr] : '0;
  end
endmodule

module sargantana_icache_way_array #(
  parameter int NUM_WAYS     = 4,
  parameter int ICACHE_DEPTH = 64,
  parameter int SET_WIDHT    = 256,
  parameter int ADDR_WIDHT   = 6
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          flush_i,
  input  logic                          req_i,
  input  logic                          we_i,
  input  logic [NUM_WAYS-1:0]           way_en_i,
  input  logic [ADDR_WIDHT-1:0]         addr_i,
  input  logic [SET_WIDHT-1:0]          data_i,
  output logic                          ready_o,
  output logic                          busy_o,
  output logic                          valid_o,
  output logic [NUM_WAYS*SET_WIDHT-1:0] data_o
);
  typedef enum logic {SWEEP, READY} state_t;
  typedef struct packed {
    logic wr;
    logic rd;
    logic hit;
  } acc_t;

  localparam logic [ADDR_WIDHT-1:0] LAST_IDX = ADDR_WIDHT'(ICACHE_DEPTH - 1);
  localparam logic [ADDR_WIDHT:0]   DEPTH_L  = (ADDR_WIDHT + 1)'(ICACHE_DEPTH);

  state_t                             state;
  logic [ADDR_WIDHT-1:0]              cnt;
  logic                               valid_q;
  acc_t                               acc;
  logic                               sweeping;
  logic [ADDR_WIDHT-1:0]              bank_addr;
  logic [SET_WIDHT-1:0]               bank_wdata;
  logic                               bank_clr;
  logic [NUM_WAYS-1:0]                bank_we;
  logic [NUM_WAYS-1:0]                bank_sel;
  logic [NUM_WAYS-1:0][SET_WIDHT-1:0] rd_data;

  assign sweeping = (state == SWEEP);
  assign ready_o  = (state == READY);
  assign busy_o   = sweeping;
  assign valid_o  = valid_q;
  assign data_o   = rd_data;

  // A flush in the same cycle as a request always wins and drops the request.
  always_comb begin
    acc     = '0;
    acc.hit = ({1'b0, addr_i} < DEPTH_L);
    acc.wr  = ready_o & req_i & we_i & ~flush_i & acc.hit;
    acc.rd  = ready_o & req_i & ~we_i & ~flush_i;
  end

  assign bank_addr  = sweeping ? cnt : addr_i;
  assign bank_wdata = sweeping ? '0 : data_i;
  assign bank_clr   = sweeping | flush_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state   <= SWEEP;
      cnt     <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        SWEEP: begin
          valid_q <= 1'b0;
          if (flush_i) begin
            cnt <= '0;
          end else if (cnt == LAST_IDX) begin
            cnt   <= '0;
            state <= READY;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          valid_q <= acc.rd;
          if (flush_i) begin
            cnt   <= '0;
            state <= SWEEP;
          end
        end
      endcase
    end
  end

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    assign bank_we[w]  = sweeping | (acc.wr & way_en_i[w]);
    assign bank_sel[w] = acc.hit & way_en_i[w];

    sargantana_icache_way_bank #(
      .ICACHE_DEPTH(ICACHE_DEPTH),
      .SET_WIDHT   (SET_WIDHT),
      .ADDR_WIDHT  (ADDR_WIDHT)
    ) u_bank (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .wr_en  (bank_we[w]),
      .rd_load(acc.rd),
      .rd_sel (bank_sel[w]),
      .clr    (bank_clr),
      .addr   (bank_addr),
      .wdata  (bank_wdata),
      .rdata  (rd_data[w])
    );
  end
endmodule

// File: tb/tb_sargantana_icache_way_array.sv
// Directed bench for the icache way array: vector table for READY-state accesses,
// hand sequences for reset/flush sweeps and a reset pulse during streaming reads.
module tb_sargantana_icache_way_array;
  localparam int NW = 4;
  localparam int SW = 256;
  localparam int AW = 6;

  logic              clk, rstn, flush, req, we;
  logic [NW-1:0]     way_en;
  logic [AW-1:0]     addr;
  logic [SW-1:0]     data;
  logic              ready, busy, valid;
  logic [NW*SW-1:0]  data_o;

  int tests = 0;
  int fails = 0;

  sargantana_icache_way_array #(
    .NUM_WAYS(NW), .ICACHE_DEPTH(64), .SET_WIDHT(SW), .ADDR_WIDHT(AW)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .flush_i(flush), .req_i(req), .we_i(we),
    .way_en_i(way_en), .addr_i(addr), .data_i(data),
    .ready_o(ready), .busy_o(busy), .valid_o(valid), .data_o(data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              req;
    logic              we;
    logic [NW-1:0]     way_en;
    logic [AW-1:0]     addr;
    logic [SW-1:0]     wdata;
    logic              exp_valid;
    logic [NW-1:0][SW-1:0] exp_data;
  } vec_t;

  localparam logic [SW-1:0] Z   = '0;
  localparam logic [SW-1:0] A5  = {32{8'hA5}};
  localparam logic [SW-1:0] C3  = {32{8'hC3}};
  localparam logic [SW-1:0] P5A = {32{8'h5A}};
  localparam logic [SW-1:0] P77 = {32{8'h77}};
  localparam logic [SW-1:0] FF  = {32{8'hFF}};

  task automatic chk(input string nm, input logic [SW-1:0] got, input logic [SW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic f, input logic r, input logic w, input logic [NW-1:0] en,
                       input logic [AW-1:0] a, input logic [SW-1:0] d);
    flush = f; req = r; we = w; way_en = en; addr = a; data = d;
  endtask

  task automatic wait_sweep(output int n, output bit saw_valid);
    n = 0;
    saw_valid = 1'b0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
      if (valid) saw_valid = 1'b1;
    end
  endtask

  function automatic vec_t mk(input logic r, input logic w, input logic [NW-1:0] en,
                              input logic [AW-1:0] a, input logic [SW-1:0] d, input logic ev,
                              input logic [SW-1:0] e3, input logic [SW-1:0] e2,
                              input logic [SW-1:0] e1, input logic [SW-1:0] e0);
    vec_t v;
    v.req = r; v.we = w; v.way_en = en; v.addr = a; v.wdata = d; v.exp_valid = ev;
    v.exp_data = {e3, e2, e1, e0};
    return v;
  endfunction

  vec_t vecs[13];

  initial begin
    int n;
    bit sv;
    logic [7:0] b;

    vecs[0]  = mk(1, 1, 4'b0101,  5, A5,  0, Z,   Z,  Z,   Z);
    vecs[1]  = mk(1, 0, 4'b1111,  5, Z,   1, Z,   A5, Z,   A5);
    vecs[2]  = mk(0, 0, 4'b1111,  5, Z,   0, Z,   A5, Z,   A5);
    vecs[3]  = mk(1, 1, 4'b1111, 10, C3,  0, Z,   A5, Z,   A5);
    vecs[4]  = mk(1, 0, 4'b0110, 10, Z,   1, Z,   C3, C3,  Z);
    vecs[5]  = mk(1, 0, 4'b0000,  5, Z,   1, Z,   Z,  Z,   Z);
    vecs[6]  = mk(1, 1, 4'b1010,  5, P5A, 0, Z,   Z,  Z,   Z);
    vecs[7]  = mk(1, 0, 4'b1111,  5, Z,   1, P5A, A5, P5A, A5);
    vecs[8]  = mk(1, 1, 4'b0000,  7, P77, 0, P5A, A5, P5A, A5);
    vecs[9]  = mk(1, 0, 4'b1111,  7, Z,   1, Z,   Z,  Z,   Z);
    vecs[10] = mk(1, 1, 4'b1111, 63, FF,  0, Z,   Z,  Z,   Z);
    vecs[11] = mk(1, 0, 4'b1000, 63, Z,   1, FF,  Z,  Z,   Z);
    vecs[12] = mk(0, 0, 4'b0000,  0, Z,   0, FF,  Z,  Z,   Z);

    // Reset state and initial sweep
    rstn = 1'b0;
    drive(0, 0, 0, '0, '0, '0);
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 1);
    chk("rst_valid", valid, 0);
    chk("rst_data_zero", data_o == '0, 1);
    rstn = 1'b1;
    wait_sweep(n, sv);
    chk("init_sweep_len", n, 64);
    chk("init_sweep_no_valid", sv, 0);
    chk("init_ready", ready, 1);

    // Back-to-back reads of every index after the sweep
    for (int i = 0; i < 64; i++) begin
      drive(0, 1, 0, 4'b1111, AW'(i), '0);
      @(negedge clk);
      chk($sformatf("init_rd%0d_valid", i), valid, 1);
      chk($sformatf("init_rd%0d_zero", i), data_o == '0, 1);
    end
    drive(0, 0, 0, '0, '0, '0);
    @(negedge clk);
    chk("init_rd_idle_valid", valid, 0);

    // Vector table: one cycle per record, result sampled after the edge
    for (int i = 0; i < 13; i++) begin
      drive(0, vecs[i].req, vecs[i].we, vecs[i].way_en, vecs[i].addr, vecs[i].wdata);
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), valid, vecs[i].exp_valid);
      chk($sformatf("v%0d_ready", i), ready, 1);
      for (int w = 0; w < NW; w++)
        chk($sformatf("v%0d_way%0d", i, w), data_o[w*SW +: SW], vecs[i].exp_data[w]);
    end

    // Flush together with a write; writes during the sweep are ignored
    drive(1, 1, 1, 4'b1111, 20, {32{8'hEE}});
    @(negedge clk);
    drive(0, 1, 1, 4'b1111, 2, {32{8'hAA}});
    chk("flush_busy", busy, 1);
    chk("flush_valid", valid, 0);
    chk("flush_data_cleared", data_o == '0, 1);
    wait_sweep(n, sv);
    chk("flush_sweep_len", n, 64);
    chk("flush_no_valid", sv, 0);
    drive(0, 1, 0, 4'b1111, 20, '0);
    @(negedge clk);
    chk("flush_rd20_valid", valid, 1);
    chk("flush_rd20_zero", data_o == '0, 1);
    drive(0, 1, 0, 4'b1111, 2, '0);
    @(negedge clk);
    chk("flush_rd2_zero", data_o == '0, 1);
    drive(0, 1, 0, 4'b1111, 63, '0);
    @(negedge clk);
    chk("flush_rd63_valid", valid, 1);
    chk("flush_rd63_zero", data_o == '0, 1);

    // Flush at sweep cycle 30 restarts the count
    drive(1, 0, 0, '0, '0, '0);
    @(negedge clk);
    flush = 1'b0;
    repeat (30) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("restart_busy", busy, 1);
    wait_sweep(n, sv);
    chk("restart_sweep_len", n, 64);

    // Distinct writes, 8 streaming reads, then reset mid-stream
    for (int i = 0; i < 8; i++) begin
      b = 8'h10 + 8'(i);
      drive(0, 1, 1, 4'b1111, AW'(i), {32{b}});
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      b = 8'h10 + 8'(i);
      drive(0, 1, 0, 4'b1001, AW'(i), '0);
      @(negedge clk);
      chk($sformatf("str%0d_valid", i), valid, 1);
      chk($sformatf("str%0d_way0", i), data_o[0 +: SW], {32{b}});
      chk($sformatf("str%0d_way1", i), data_o[SW +: SW], Z);
      chk($sformatf("str%0d_way3", i), data_o[3*SW +: SW], {32{b}});
    end
    drive(0, 1, 0, 4'b1111, 1, '0);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_valid", valid, 0);
    chk("midrst_data_zero", data_o == '0, 1);
    chk("midrst_busy", busy, 1);
    @(negedge clk);
    rstn = 1'b1;
    wait_sweep(n, sv);
    chk("midrst_sweep_len", n, 64);
    chk("midrst_no_valid", sv, 0);
    drive(0, 1, 0, 4'b1111, 3, '0);
    @(negedge clk);
    chk("midrst_rd3_valid", valid, 1);
    chk("midrst_rd3_zero", data_o == '0, 1);
    drive(0, 0, 0, '0, '0, '0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sargantana_icache_way_array.md
SARGANTANA_ICACHE_WAY_ARRAY -- requirements
Module: sargantana_icache_way_array

Interface
REQ-001 Parameter NUM_WAYS, default 4, number of independent way arrays (>=1).
REQ-002 Parameter ICACHE_DEPTH, default 64, lines per way (>=2, <=2**ADDR_WIDHT).
REQ-003 Parameter SET_WIDHT, default 256, bits per line.
REQ-004 Parameter ADDR_WIDHT, default 6, line index width.
REQ-005 clk_i  in  1  single clock, all state on rising edge.
REQ-006 rstn_i  in  1  reset, asynchronous, active-low.
REQ-007 flush_i  in  1  request invalidation sweep of all ways.
REQ-008 req_i  in  1  access request, accepted only when ready_o=1.
REQ-009 we_i  in  1  1=write, 0=read (qualified by req_i).
REQ-010 way_en_i  in  NUM_WAYS  per-way select, bit w targets way w.
REQ-011 addr_i  in  ADDR_WIDHT  line index.
REQ-012 data_i  in  SET_WIDHT  write data, same for all selected ways.
REQ-013 ready_o  out  1  array accepts requests this cycle.
REQ-014 busy_o  out  1  init/flush sweep in progress.
REQ-015 valid_o  out  1  one-cycle pulse, data_o carries read result.
REQ-016 data_o  out  NUM_WAYS*SET_WIDHT  read data, way w at bits [w*SET_WIDHT +: SET_WIDHT].

Function
REQ-017 FSM states SWEEP and READY only; ready_o=1 iff state READY; busy_o=1 iff state SWEEP.
REQ-018 SWEEP: sweep counter cnt (ADDR_WIDHT bits) writes all-zero line at index cnt into every way, one index per cycle, independent of way_en_i.
REQ-019 SWEEP transitions to READY on the cycle cnt=ICACHE_DEPTH-1 is written; sweep lasts exactly ICACHE_DEPTH cycles; cnt then returns to 0.
REQ-020 READY transitions to SWEEP with cnt=0 on flush_i=1; flush_i=1 during SWEEP restarts cnt at 0.
REQ-021 flush_i and req_i in same READY cycle: flush wins, request discarded, no write, no valid_o.
REQ-022 req_i while ready_o=0 is ignored (no storage change, no valid_o); requester holds or drops at its choice.
REQ-023 Write (READY, req_i=1, we_i=1): data_i written at addr_i into every way with way_en_i[w]=1 at the clock edge; other ways unchanged; valid_o stays 0.
REQ-024 Read (READY, req_i=1, we_i=0): one-cycle latency; next cycle valid_o=1 and data_o slice w = stored line at addr_i for selected ways, all-zero for unselected ways.
REQ-025 data_o and the selection mask are registered and hold until the next accepted read or a sweep start; valid_o is 1 for exactly one cycle per accepted read.
REQ-026 Back-to-back reads every cycle sustained at full throughput, one valid_o per accepted read.
REQ-027 Read of an index written in the immediately preceding cycle returns the new data.
REQ-028 addr_i >= ICACHE_DEPTH: write suppressed; read returns all-zero data_o with valid_o=1.
REQ-029 way_en_i=0 with req_i=1: write is a no-op; read returns all zeros with valid_o=1.
REQ-030 Storage is not reset directly; cleared contents guaranteed only via the sweep.
REQ-031 Entering SWEEP clears data_o to zero and valid_o to 0 on the same edge.

Reset
REQ-032 rstn_i=0 asynchronously forces state SWEEP, cnt=0, valid_o=0, data_o=0, ready_o=0, busy_o=1.
REQ-033 Reset asserted mid-sweep or mid-read aborts the operation; after release the full ICACHE_DEPTH-cycle sweep runs from index 0.
REQ-034 First accepted request possible on the cycle after the final sweep write (cycle ICACHE_DEPTH after reset release).

Verification
REQ-035 Reset release with defaults -> busy_o=1 for exactly 64 cycles, then ready_o=1; read of every index, all ways -> data_o all zero, valid_o pulses.
REQ-036 Write index 5, way_en_i=4'b0101, data_i=0xA5 pattern; read index 5, way_en_i=4'b1111 next cycle -> ways 0,2 = 0xA5 pattern, ways 1,3 = 0, valid_o=1 one cycle.
REQ-037 Write index 63 ways all, then flush_i=1 -> busy_o=1 64 cycles, requests ignored meanwhile; read index 63 after -> all zero.
REQ-038 flush_i=1 at sweep cycle 30 -> sweep restarts, ready_o rises 64 cycles after the restart edge.
REQ-039 flush_i=1 with write req same cycle -> write discarded; after sweep, read returns zero.
REQ-040 Reads to indices 0..7 on 8 consecutive cycles after distinct writes -> 8 consecutive valid_o cycles with matching data in order; rstn_i pulsed low mid-stream -> valid_o=0 and data_o=0 immediately, no further valid_o until sweep completes.
